// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: validates the start bit, centres data samples on the
// oversampled line, and drives shift/load strobes with parity, framing and overrun status.
module uart_rx_ctrl #(
   parameter int WIDTH      = 8,
   parameter int OSR        = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic baud_tick,
   input  logic rx,
   output logic shift_en,
   output logic rx_bit,
   output logic d_load,
   output logic d_ready,
   input  logic d_ack,
   output logic p_error,
   output logic f_error,
   output logic overrun,
   output logic busy
);

   localparam int SC_W = $clog2(OSR);
   localparam int BC_W = $clog2(WIDTH);
   localparam logic [SC_W-1:0] SC_MID  = SC_W'(OSR / 2 - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OSR - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          state, state_nx;
   logic [SC_W-1:0] sample_cnt, sample_cnt_nx;
   logic [BC_W-1:0] bit_cnt, bit_cnt_nx;
   logic            parity_acc, parity_acc_nx;
   logic            armed, armed_nx;
   logic            perr_frame, perr_frame_nx;
   logic            frame_done;
   logic            shift_en_nx, rx_bit_nx, d_load_nx, overrun_nx;
   logic            d_ready_nx, p_error_nx, f_error_nx;

   function automatic logic parity_fail(input logic acc, input logic pbit);
      return (acc ^ pbit) != (PARITY_ODD != 0);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         parity_acc <= 1'b0;
         armed      <= 1'b0;
         perr_frame <= 1'b0;
         shift_en   <= 1'b0;
         rx_bit     <= 1'b0;
         d_load     <= 1'b0;
         d_ready    <= 1'b0;
         p_error    <= 1'b0;
         f_error    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nx;
         sample_cnt <= sample_cnt_nx;
         bit_cnt    <= bit_cnt_nx;
         parity_acc <= parity_acc_nx;
         armed      <= armed_nx;
         perr_frame <= perr_frame_nx;
         shift_en   <= shift_en_nx;
         rx_bit     <= rx_bit_nx;
         d_load     <= d_load_nx;
         d_ready    <= d_ready_nx;
         p_error    <= p_error_nx;
         f_error    <= f_error_nx;
         overrun    <= overrun_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      sample_cnt_nx = sample_cnt;
      bit_cnt_nx    = bit_cnt;
      parity_acc_nx = parity_acc;
      armed_nx      = armed;
      perr_frame_nx = perr_frame;
      frame_done    = 1'b0;
      shift_en_nx   = 1'b0;
      rx_bit_nx     = rx_bit;
      d_load_nx     = 1'b0;
      overrun_nx    = 1'b0;
      d_ready_nx    = d_ready;
      p_error_nx    = p_error;
      f_error_nx    = f_error;

      if (baud_tick) begin
         case (state)
            S_IDLE: begin
               // A falling edge only counts once the line has been seen high.
               if (rx) begin
                  armed_nx = 1'b1;
               end else if (armed) begin
                  state_nx      = S_START;
                  sample_cnt_nx = '0;
               end
            end
            S_START: begin
               if (sample_cnt == SC_MID) begin
                  if (!rx) begin
                     state_nx      = S_DATA;
                     sample_cnt_nx = '0;
                     bit_cnt_nx    = '0;
                     parity_acc_nx = 1'b0;
                     perr_frame_nx = 1'b0;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else begin
                  sample_cnt_nx = sample_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (sample_cnt == SC_LAST) begin
                  shift_en_nx   = 1'b1;
                  rx_bit_nx     = rx;
                  sample_cnt_nx = '0;
                  parity_acc_nx = parity_acc ^ rx;
                  if (bit_cnt == BC_LAST) begin
                     state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt_nx = bit_cnt + 1'b1;
                  end
               end else begin
                  sample_cnt_nx = sample_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (sample_cnt == SC_LAST) begin
                  perr_frame_nx = parity_fail(parity_acc, rx);
                  sample_cnt_nx = '0;
                  state_nx      = S_STOP;
               end else begin
                  sample_cnt_nx = sample_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (sample_cnt == SC_LAST) begin
                  // A low stop bit disarms so a held break cannot retrigger.
                  frame_done    = 1'b1;
                  armed_nx      = rx;
                  sample_cnt_nx = '0;
                  state_nx      = S_IDLE;
               end else begin
                  sample_cnt_nx = sample_cnt + 1'b1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end

      if (frame_done) begin
         if (!d_ready || d_ack) begin
            d_load_nx  = 1'b1;
            d_ready_nx = 1'b1;
            p_error_nx = (PARITY_EN != 0) && perr_frame;
            f_error_nx = !rx;
         end else begin
            overrun_nx = 1'b1;
         end
      end else if (d_ack && d_ready) begin
         d_ready_nx = 1'b0;
         p_error_nx = 1'b0;
         f_error_nx = 1'b0;
      end
   end

   assign busy = (state != S_IDLE);

endmodule
